alu_opnd_seq: RTL
=================

# alu_opnd_seq

Parametrised operand selector and slice sequencer for the ALU datapath. Each cycle it selects one of `NSRC` source buses or a forced zero. On request it captures the selected operand into an internal register. It then delivers the operand to the narrow ALU core one `SLICE`-bit slice per handshake, least-significant or most-significant slice first. It replaces the combinational 3-way op1 mux and adds more source channels, configurable width, a capture register, slice sequencing and select-conflict detection.

## Interface
- `NSRC`, 4, number of source buses (≥2)
- `WIDTH`, 8, operand width in bits
- `SLICE`, 4, bits delivered per beat; `WIDTH` must be a multiple of `SLICE`; `NSLICE = WIDTH/SLICE` (≥1)

Ports:
- `clk` in 1: the block's single clock.
- `reset` in 1: synchronous, active-high; sampled on the rising edge of `clk`.
- `sel` in NSRC: one-hot source select; bit i selects `src[i*WIDTH +: WIDTH]`.
- `sel_zero` in 1: forces the selected operand to 0; takes priority over `sel`.
- `src` in NSRC*WIDTH: flattened source buses.
- `load` in 1: request to capture the selected operand.
- `dir` in 1: slice order, sampled with `load`; 0 = LSB slice first, 1 = MSB slice first.
- `q_ready` in 1: consumer accepts the current slice.
- `ena` out 1: combinational, `sel_zero | (|sel)`; a valid selection is present.
- `busy` out 1: registered; 1 while in SHIFT.
- `q` out SLICE: current slice.
- `q_valid` out 1: registered; the value on `q` is valid.
- `q_last` out 1: the current slice is the final slice of the operand.
- `conflict` out 1: sticky; an unresolved multi-hot `sel` was captured.

## Operation
- Operand selection (combinational), called `opnd`:
  - if `sel_zero` = 1: `opnd` = 0, regardless of `sel`;
  - else if `sel` = 0: `opnd` = 0;
  - else if `sel` is one-hot: `opnd` = the selected source;
  - else (multi-hot): `opnd` = 0. This case is a conflict.
- Capture condition: a capture occurs when `load` & `ena` are high while the FSM is in IDLE, or on the final-slice handshake in SHIFT. `load` with `ena` = 0 is ignored.
- State machine:
  - IDLE: `q_valid` = 0. On a capture: store `opnd` and `dir`, set slice index to 0, go to SHIFT.
  - SHIFT: `q_valid` = 1.
    - `q` = slice[idx] when `dir` = 0; slice[NSLICE-1-idx] when `dir` = 1.
    - `q_last` = (idx == NSLICE-1).
    - Handshake (`q_valid` & `q_ready`) on a non-last slice: idx increments.
    - Handshake on the last slice: if `load` & `ena` are high in the same cycle, capture the new operand, reset idx to 0 and stay in SHIFT (back-to-back). Otherwise go to IDLE.
    - `load` on any other SHIFT cycle is ignored; the caller must watch `busy`.
- `conflict` sets on any capture where `sel_zero` = 0 and `sel` has more than one bit set. It stays set until `reset`. A zero-forced capture with a multi-hot `sel` does not set it.
- `NSLICE` = 1: the first slice is also the last. Each capture yields a one-beat transfer.
- `q`, `q_last` and `busy` are registered or decoded from registered state only; there is no combinational path from `src` to `q`.

## Timing
- Reset values: FSM = IDLE, operand register = 0, idx = 0, `q` = 0, `q_valid` = 0, `q_last` = 0, `busy` = 0, `conflict` = 0. `ena` follows its inputs even during reset.
- Latency: a capture at rising edge k gives `q_valid` = 1 with slice 0 on `q` from edge k onward.
- Throughput: one operand per NSLICE cycles when `q_ready` is held high and back-to-back loads are used. There is no idle bubble.
- Stall: with `q_ready` = 0, `q`, `q_valid`, `q_last` and idx hold indefinitely.
- `reset` asserted mid-transfer forces every output to its reset value at the next edge. The partially sent operand is discarded, and `load` is ignored in that cycle.
- Capture samples `src`, `sel`, `sel_zero` and `dir` only at the capture edge. Later changes to these inputs do not affect the operand in flight.

## Test plan
All cases use `NSRC`=4, `WIDTH`=8, `SLICE`=4.
- Reset: assert `reset` for 2 cycles with `load`=1 and `sel`=0001 → `q_valid`=0, `q`=0, `busy`=0, `conflict`=0. Then drive `sel`=0000, `sel_zero`=0 → `ena`=0.
- LSB-first transfer: `src[1]`=0xA5, `sel`=0010, `dir`=0, `load` pulse, `q_ready`=1 → `q`=0x5 with `q_last`=0, then `q`=0xA with `q_last`=1, then `q_valid`=0. Changing `src[1]` after the capture has no effect.
- Zero priority: `sel_zero`=1, `sel`=1111, `load` → two slices of 0x0 are delivered; `conflict` stays 0.
- Conflict: `sel`=0011, `sel_zero`=0, `load` → slices 0x0, 0x0 are delivered; `conflict`=1 and stays 1 after a later clean load.
- MSB-first with stall: `src[2]`=0x3C, `dir`=1, `q_ready` low for 3 cycles → `q`=0x3 held for 3 cycles; once `q_ready` rises, `q`=0xC with `q_last`=1.
- Back-to-back and reset mid-op:
  - `load` asserted on the last handshake of 0xA5 with `src[0]`=0x96 selected → the next cycle shows `q`=0x6 with no IDLE gap.
  - `reset` asserted during the 0x6 beat → `q_valid`=0 on the following cycle.

Source files
------------

// File: rtl/alu_opnd_seq_if.sv
// rtl/alu_opnd_seq_if.sv - operand source select / slice stream bundle
//
// Purpose: groups the source-select inputs and the slice-stream outputs of
// alu_opnd_seq so the block and its caller share one typed bundle.
// Ports (signals):
//   sel[NSRC], sel_zero, src[NSRC*WIDTH], load, dir, q_ready : caller -> block
//   ena, busy, q[SLICE], q_valid, q_last, conflict           : block -> caller
// Modports: master (caller side), slave (alu_opnd_seq side).
interface alu_opnd_seq_if #(
    parameter int NSRC  = 4,
    parameter int WIDTH = 8,
    parameter int SLICE = 4
);
    logic [NSRC-1:0]       sel;
    logic                  sel_zero;
    logic [NSRC*WIDTH-1:0] src;
    logic                  load;
    logic                  dir;
    logic                  q_ready;
    logic                  ena;
    logic                  busy;
    logic [SLICE-1:0]      q;
    logic                  q_valid;
    logic                  q_last;
    logic                  conflict;

    modport master (
        output sel, sel_zero, src, load, dir, q_ready,
        input  ena, busy, q, q_valid, q_last, conflict
    );

    modport slave (
        input  sel, sel_zero, src, load, dir, q_ready,
        output ena, busy, q, q_valid, q_last, conflict
    );
endinterface

// File: rtl/alu_opnd_seq.sv
// rtl/alu_opnd_seq.sv - operand selector, capture register and slice sequencer
//
// Purpose: selects one of NSRC source buses (or a forced zero), captures it on
// load, then streams it to the narrow ALU core SLICE bits per handshake,
// LSB-first (dir=0) or MSB-first (dir=1). Flags multi-hot selections.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : alu_opnd_seq_if.slave (sel, sel_zero, src, load, dir, q_ready in;
//           ena, busy, q, q_valid, q_last, conflict out)
module alu_opnd_seq #(
    parameter int NSRC  = 4,
    parameter int WIDTH = 8,
    parameter int SLICE = 4
) (
    input  logic          clk,
    input  logic          reset,
    alu_opnd_seq_if.slave bus
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_opnd;
    logic [IDXW-1:0]  r_idx;
    logic             r_dir;
    logic             r_conflict;

    logic [WIDTH-1:0] w_sel_or;
    logic [WIDTH-1:0] w_opnd;
    logic             w_multi;
    logic             w_ena;
    logic             w_last;
    logic             w_take;
    logic [IDXW-1:0]  w_pos;
    logic [SLICE-1:0] w_slice;

    // x & (x-1) clears the lowest set bit; anything left means multi-hot.
    assign w_multi = (bus.sel & (bus.sel - NSRC'(1))) != '0;
    assign w_ena   = bus.sel_zero | (|bus.sel);

    always_comb begin
        w_sel_or = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (bus.sel[i]) begin
                w_sel_or = w_sel_or | bus.src[i*WIDTH +: WIDTH];
            end
        end
    end

    // sel==0 already yields zero from the OR tree; multi-hot is forced to zero.
    assign w_opnd = (bus.sel_zero || w_multi) ? '0 : w_sel_or;

    assign w_last = (r_idx == LAST_IDX);

    // In SHIFT q_valid is always 1, so a handshake is just q_ready. A new
    // capture is only taken from IDLE or on the final-slice handshake.
    assign w_take = bus.load & w_ena &
                    ((r_state == IDLE) | (bus.q_ready & w_last));

    assign w_pos = r_dir ? (LAST_IDX - r_idx) : r_idx;

    always_comb begin
        w_slice = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (w_pos == IDXW'(i)) begin
                w_slice = r_opnd[i*SLICE +: SLICE];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_opnd     <= '0;
            r_idx      <= '0;
            r_dir      <= 1'b0;
            r_conflict <= 1'b0;
        end else if (w_take) begin
            r_state <= SHIFT;
            r_opnd  <= w_opnd;
            r_dir   <= bus.dir;
            r_idx   <= '0;
            if (!bus.sel_zero && w_multi) begin
                r_conflict <= 1'b1;
            end
        end else if (r_state == SHIFT && bus.q_ready) begin
            if (w_last) begin
                r_state <= IDLE;
            end else begin
                r_idx <= r_idx + IDXW'(1);
            end
        end
    end

    // All stream outputs decode registered state only; src never reaches q.
    assign bus.ena      = w_ena;
    assign bus.busy     = (r_state == SHIFT);
    assign bus.q_valid  = (r_state == SHIFT);
    assign bus.q_last   = (r_state == SHIFT) & w_last;
    assign bus.q        = (r_state == SHIFT) ? w_slice : '0;
    assign bus.conflict = r_conflict;
endmodule
